// File: rtl/feed_pkg.sv
// Shared message types and field positions for the redundant-feed merger.
package feed_pkg;
    localparam int MSG_W   = 168;
    localparam int SEQ_LSB = 8;
    localparam int SEQ_MSB = 39;

    typedef logic [MSG_W-1:0] msg_t;
    typedef logic [31:0]      seq_t;

    typedef enum logic {
        FEED_A = 1'b0,
        FEED_B = 1'b1
    } feed_t;

    function automatic seq_t get_seq(input msg_t msg);
        return msg[SEQ_MSB:SEQ_LSB];
    endfunction
endpackage

// File: rtl/seq_window.sv
// Tracks next expected sequence number and a seen-bitmap past it; classifies
// each accepted message and advances the window by one step per cycle.
module seq_window
    import feed_pkg::*;
#(
    parameter int WINDOW  = 50,
    parameter int TIMEOUT = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic accept,
    input  seq_t seq,
    output logic fwd,
    output logic dup,
    output logic drop,
    output seq_t next_seq,
    output logic gap_skip
);
    localparam int IDX_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [WINDOW-1:0] ONE      = WINDOW'(1);

    logic [WINDOW-1:0] seen;
    logic [WINDOW-1:0] seen_nxt;
    logic [WINDOW-1:0] seen_at;
    logic [TMR_W-1:0]  timer;
    seq_t              diff;
    logic [IDX_W-1:0]  idx;
    logic              behind;
    logic              ahead;
    logic              hit;

    // Classification uses the pre-advance next_seq; modulo diff handles wrap.
    always_comb begin
        diff     = seq - next_seq;
        idx      = diff[IDX_W-1:0];
        behind   = diff[31];
        ahead    = !behind && (diff >= seq_t'(WINDOW));
        seen_at  = seen >> idx;
        hit      = seen_at[0];
        dup      = accept && (behind || (!ahead && hit));
        drop     = accept && ahead;
        fwd      = accept && !behind && !ahead && !hit;
        seen_nxt = fwd ? (seen | (ONE << idx)) : seen;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            next_seq <= '0;
            seen     <= '0;
            timer    <= '0;
            gap_skip <= 1'b0;
        end else begin
            gap_skip <= 1'b0;
            if (seen_nxt[0]) begin
                next_seq <= next_seq + 32'd1;
                seen     <= seen_nxt >> 1;
                timer    <= '0;
            end else if (seen_nxt != '0) begin
                if (timer == TMR_LAST) begin
                    next_seq <= next_seq + 32'd1;
                    seen     <= seen_nxt >> 1;
                    timer    <= '0;
                    gap_skip <= 1'b1;
                end else begin
                    seen  <= seen_nxt;
                    timer <= timer + TMR_W'(1);
                end
            end else begin
                seen  <= seen_nxt;
                timer <= '0;
            end
        end
    end
endmodule

// File: rtl/feed_arbiter.sv
// Round-robin merge of feeds A and B with duplicate/out-of-window removal and
// a single-register output stage.
module feed_arbiter
    import feed_pkg::*;
#(
    parameter int WINDOW  = 50,
    parameter int TIMEOUT = 1000,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a_valid,
    input  logic [MSG_W-1:0] a_msg,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [MSG_W-1:0] b_msg,
    output logic             b_ready,
    output logic             out_valid,
    output logic [MSG_W-1:0] out_msg,
    input  logic             out_ready,
    output logic [31:0]      next_seq,
    output logic             gap_skip,
    output logic [CNT_W-1:0] dup_count,
    output logic [CNT_W-1:0] drop_count
);
    feed_t rr;
    logic  can_take;
    logic  grant_a;
    logic  grant_b;
    logic  accept;
    msg_t  sel_msg;
    seq_t  sel_seq;
    logic  fwd;
    logic  dup;
    logic  drop;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    // No grant during reset so nothing is consumed and then thrown away.
    always_comb begin
        can_take = !out_valid || out_ready;
        grant_a  = !reset && can_take && a_valid && (!b_valid || rr == FEED_A);
        grant_b  = !reset && can_take && b_valid && (!a_valid || rr == FEED_B);
        accept   = grant_a || grant_b;
        sel_msg  = grant_b ? b_msg : a_msg;
        sel_seq  = get_seq(sel_msg);
    end

    assign a_ready = grant_a;
    assign b_ready = grant_b;

    seq_window #(
        .WINDOW  (WINDOW),
        .TIMEOUT (TIMEOUT)
    ) u_window (
        .clk      (clk),
        .reset    (reset),
        .accept   (accept),
        .seq      (sel_seq),
        .fwd      (fwd),
        .dup      (dup),
        .drop     (drop),
        .next_seq (next_seq),
        .gap_skip (gap_skip)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            rr         <= FEED_A;
            out_valid  <= 1'b0;
            out_msg    <= '0;
            dup_count  <= '0;
            drop_count <= '0;
        end else begin
            if (grant_a && b_valid) begin
                rr <= FEED_B;
            end else if (grant_b && a_valid) begin
                rr <= FEED_A;
            end
            if (fwd) begin
                out_valid <= 1'b1;
                out_msg   <= sel_msg;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (dup) begin
                dup_count <= sat_inc(dup_count);
            end
            if (drop) begin
                drop_count <= sat_inc(drop_count);
            end
        end
    end
endmodule
